// File: rtl/regfile_sb_if.sv
// regfile_sb_if: groups the read, write, allocation and flush signals of the
// scoreboarded register file into one bundle.
//   master : the pipeline side (drives addresses, write data, alloc, flush)
//   slave  : the register file (returns read data, ready bits, alloc_ok, busy_cnt)
// Ports (width):
//   raddr NREAD*ADDR_W, rdata NREAD*DATA_W, rready NREAD,
//   we NWRITE, waddr NWRITE*ADDR_W, wdata NWRITE*DATA_W,
//   alloc_valid 1, alloc_addr ADDR_W, alloc_ok 1, flush 1, busy_cnt ADDR_W+1
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
);
  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rready;
  logic [NWRITE-1:0]        we;
  logic [NWRITE*ADDR_W-1:0] waddr;
  logic [NWRITE*DATA_W-1:0] wdata;
  logic                     alloc_valid;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     alloc_ok;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output raddr, we, waddr, wdata, alloc_valid, alloc_addr, flush,
    input  rdata, rready, alloc_ok, busy_cnt
  );

  modport slave (
    input  raddr, we, waddr, wdata, alloc_valid, alloc_addr, flush,
    output rdata, rready, alloc_ok, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port integer register file with a busy-bit scoreboard.
// Reads are combinational with optional same-cycle forwarding of write data.
// Writes are prioritised by port index (highest wins). An allocation marks a
// destination busy until its writeback; flush drops every pending allocation
// while keeping register contents.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high; clears data, busy bits and busy_cnt
//   bus   : regfile_sb_if slave modport (read/write/alloc/flush bundle)
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        reset,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]       rf_q [DEPTH];
  logic [DATA_W-1:0]       rf_d [DEPTH];
  logic [DEPTH-1:0]        busy_q;
  logic [DEPTH-1:0]        busy_d;
  logic [ADDR_W:0]         busy_cnt_q;
  logic [ADDR_W:0]         busy_cnt_d;

  logic [ADDR_W-1:0]       waddr_s [NWRITE];
  logic [DATA_W-1:0]       wdata_s [NWRITE];
  logic [NWRITE-1:0]       wr_eff_s;
  logic                    alloc_zero_s;
  logic                    alloc_wr_hit_s;
  logic                    alloc_ok_s;
  logic                    alloc_take_s;
  logic [NREAD*DATA_W-1:0] rdata_s;
  logic [NREAD-1:0]        rready_s;

  // Count of set bits; busy_cnt is always defined as the popcount of busy.
  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] c;
    c = {(ADDR_W+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      c = c + {{ADDR_W{1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Unpack write ports and qualify them; writes to r0 are dropped when it is hardwired.
  always_comb begin
    for (int j = 0; j < NWRITE; j++) begin
      waddr_s[j]  = bus.waddr[j*ADDR_W +: ADDR_W];
      wdata_s[j]  = bus.wdata[j*DATA_W +: DATA_W];
      wr_eff_s[j] = bus.we[j] &&
                    !((ZERO_REG != 0) && (waddr_s[j] == {ADDR_W{1'b0}}));
    end
  end

  // Allocation acceptance: a busy register may be re-allocated in the cycle its writeback lands.
  always_comb begin
    alloc_zero_s   = (ZERO_REG != 0) && (bus.alloc_addr == {ADDR_W{1'b0}});
    alloc_wr_hit_s = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      alloc_wr_hit_s = alloc_wr_hit_s |
                       (wr_eff_s[j] && (waddr_s[j] == bus.alloc_addr));
    end
    alloc_ok_s   = alloc_zero_s || !busy_q[bus.alloc_addr] || alloc_wr_hit_s;
    // r0 allocations are accepted but have no effect; flush cancels any alloc.
    alloc_take_s = bus.alloc_valid && alloc_ok_s && !alloc_zero_s && !bus.flush;
  end

  // Next-state register array; ascending port order makes the highest index win.
  always_comb begin
    rf_d = rf_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_eff_s[j]) begin
        rf_d[waddr_s[j]] = wdata_s[j];
      end else begin
        rf_d[waddr_s[j]] = rf_d[waddr_s[j]];
      end
    end
  end

  // Next-state scoreboard: writeback clears, then alloc sets (new producer wins), flush clears all.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      busy_d[waddr_s[j]] = busy_d[waddr_s[j]] & ~wr_eff_s[j];
    end
    busy_d[bus.alloc_addr] = busy_d[bus.alloc_addr] | alloc_take_s;
    if (bus.flush) begin
      busy_d = {DEPTH{1'b0}};
    end else begin
      busy_d = busy_d;
    end
    busy_cnt_d = popcount(busy_d);
  end

  // Read ports: hardwired zero, then forwarded write data, then array contents.
  always_comb begin
    rdata_s  = {(NREAD*DATA_W){1'b0}};
    rready_s = {NREAD{1'b0}};
    for (int i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              byp_hit;
      logic [DATA_W-1:0] byp_data;
      ra       = bus.raddr[i*ADDR_W +: ADDR_W];
      byp_hit  = 1'b0;
      byp_data = {DATA_W{1'b0}};
      for (int j = 0; j < NWRITE; j++) begin
        if ((BYPASS != 0) && wr_eff_s[j] && (waddr_s[j] == ra)) begin
          byp_hit  = 1'b1;
          byp_data = wdata_s[j];
        end else begin
          byp_hit  = byp_hit;
          byp_data = byp_data;
        end
      end
      if ((ZERO_REG != 0) && (ra == {ADDR_W{1'b0}})) begin
        rdata_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rready_s[i]                 = 1'b1;
      end else if (byp_hit) begin
        rdata_s[i*DATA_W +: DATA_W] = byp_data;
        rready_s[i]                 = 1'b1;
      end else begin
        rdata_s[i*DATA_W +: DATA_W] = rf_q[ra];
        rready_s[i]                 = ~busy_q[ra];
      end
    end
  end

  // State registers; reset discards everything including this cycle's writes and allocs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        rf_q[k] <= {DATA_W{1'b0}};
      end
      busy_q     <= {DEPTH{1'b0}};
      busy_cnt_q <= {(ADDR_W+1){1'b0}};
    end else begin
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.rdata    = rdata_s;
  assign bus.rready   = rready_s;
  assign bus.alloc_ok = alloc_ok_s;
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven directed vectors, a reset-in-flight sequence and
// randomized traffic checked against a behavioural register-file model.
module tb_regfile_sb;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) bus ();

  regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2), .BYPASS(1), .ZERO_REG(1)
  ) u_dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_rf [32];
  bit   [31:0] m_busy;
  int          m_cnt;

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        av;
    logic [4:0]  aa;
    logic        fl;
    logic [31:0] e_rd0;
    logic        e_rr0;
    logic [31:0] e_rd1;
    logic        e_rr1;
    logic        e_ok;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vt [18];

  function automatic vec_t mkv(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic av, input logic [4:0] aa, input logic fl,
    input logic [31:0] e_rd0, input logic e_rr0,
    input logic [31:0] e_rd1, input logic e_rr1,
    input logic e_ok, input logic [5:0] e_cnt);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.av = av; v.aa = aa; v.fl = fl;
    v.e_rd0 = e_rd0; v.e_rr0 = e_rr0; v.e_rd1 = e_rd1; v.e_rr1 = e_rr1;
    v.e_ok = e_ok; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic av, input logic [4:0] aa, input logic fl);
    bus.we          = we;
    bus.waddr       = {wa1, wa0};
    bus.wdata       = {wd1, wd0};
    bus.raddr       = {ra1, ra0};
    bus.alloc_valid = av;
    bus.alloc_addr  = aa;
    bus.flush       = fl;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Model view of a read port given the current (pre-edge) state and inputs
  task automatic model_read(input logic [4:0] ra, output logic [31:0] d, output logic r);
    d = m_rf[ra];
    r = !m_busy[ra];
    for (int j = 0; j < 2; j++) begin
      logic [4:0] wa;
      wa = bus.waddr[j*5 +: 5];
      if (bus.we[j] && wa != 5'd0 && wa == ra) begin
        d = bus.wdata[j*32 +: 32];
        r = 1'b1;
      end
    end
    if (ra == 5'd0) begin
      d = 32'h0;
      r = 1'b1;
    end
  endtask

  function automatic logic model_alloc_ok();
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < 2; j++) begin
      if (bus.we[j] && bus.waddr[j*5 +: 5] != 5'd0 && bus.waddr[j*5 +: 5] == bus.alloc_addr)
        hit = 1'b1;
    end
    return (bus.alloc_addr == 5'd0) || !m_busy[bus.alloc_addr] || hit;
  endfunction

  // Apply the architectural rules for one clock edge
  task automatic model_edge();
    logic ok;
    if (rst) begin
      for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;
      m_busy = 32'h0;
    end else begin
      ok = model_alloc_ok();
      for (int j = 0; j < 2; j++) begin
        logic [4:0] wa;
        wa = bus.waddr[j*5 +: 5];
        if (bus.we[j] && wa != 5'd0) begin
          m_rf[wa]   = bus.wdata[j*32 +: 32];
          m_busy[wa] = 1'b0;
        end
      end
      if (bus.alloc_valid && ok && bus.alloc_addr != 5'd0) m_busy[bus.alloc_addr] = 1'b1;
      if (bus.flush) m_busy = 32'h0;
    end
    m_cnt = $countones(m_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d;
    logic        r;
    for (int i = 0; i < 2; i++) begin
      model_read(bus.raddr[i*5 +: 5], d, r);
      check($sformatf("%s rdata%0d", tag, i), bus.rdata[i*32 +: 32], d);
      check($sformatf("%s rready%0d", tag, i), {31'h0, bus.rready[i]}, {31'h0, r});
    end
    check($sformatf("%s alloc_ok", tag), {31'h0, bus.alloc_ok}, {31'h0, model_alloc_ok()});
    check($sformatf("%s busy_cnt", tag), {26'h0, bus.busy_cnt}, m_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_cnt    = 0;
    m_busy   = 32'h0;
    for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;

    //       we     wa0   wd0           wa1   wd1    ra0   ra1   av    aa    fl   e_rd0         rr0   e_rd1         rr1   ok    cnt
    vt[0]  = mkv(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b1, 6'd0);
    vt[1]  = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 1'b1, 6'd0);
    vt[2]  = mkv(2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 5'd7, 5'd5, 1'b0, 5'd0, 1'b0, 32'h22,       1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 6'd0);
    vt[3]  = mkv(2'b01, 5'd0, 32'hFF,       5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h22,       1'b1, 32'h0,        1'b1, 1'b1, 6'd0);
    vt[4]  = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 6'd0);
    vt[5]  = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd7, 1'b0, 5'd9, 1'b0, 32'h0,        1'b0, 32'h22,       1'b1, 1'b0, 6'd1);
    vt[6]  = mkv(2'b01, 5'd9, 32'h1234,     5'd0, 32'h0,  5'd9, 5'd9, 1'b0, 5'd9, 1'b0, 32'h1234,     1'b1, 32'h1234,     1'b1, 1'b1, 6'd1);
    vt[7]  = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd9, 5'd3, 1'b1, 5'd3, 1'b0, 32'h1234,     1'b1, 32'h0,        1'b1, 1'b1, 6'd0);
    vt[8]  = mkv(2'b10, 5'd0, 32'h0,        5'd3, 32'hAB, 5'd3, 5'd9, 1'b1, 5'd3, 1'b0, 32'hAB,       1'b1, 32'h1234,     1'b1, 1'b1, 6'd1);
    vt[9]  = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd3, 5'd2, 1'b1, 5'd1, 1'b0, 32'hAB,       1'b0, 32'h0,        1'b1, 1'b1, 6'd1);
    vt[10] = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd1, 5'd3, 1'b1, 5'd2, 1'b0, 32'h0,        1'b0, 32'hAB,       1'b0, 1'b1, 6'd2);
    vt[11] = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd2, 5'd4, 1'b1, 5'd4, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 6'd3);
    vt[12] = mkv(2'b01, 5'd10, 32'h77,      5'd0, 32'h0,  5'd4, 5'd6, 1'b1, 5'd6, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 6'd4);
    vt[13] = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd6, 5'd10, 1'b0, 5'd6, 1'b0, 32'h0,       1'b1, 32'h77,       1'b1, 1'b1, 6'd0);
    vt[14] = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd3, 5'd2, 1'b0, 5'd3, 1'b0, 32'hAB,       1'b1, 32'h0,        1'b1, 1'b1, 6'd0);
    vt[15] = mkv(2'b00, 5'd5, 32'h1,        5'd5, 32'h2,  5'd5, 5'd9, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b1, 32'h1234,     1'b1, 1'b1, 6'd0);
    vt[16] = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 32'h0,        1'b1, 32'h22,       1'b1, 1'b1, 6'd0);
    vt[17] = mkv(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b1, 6'd0);

    // Reset
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;

    // Post-reset: every register reads zero and is ready
    for (int r = 0; r < 32; r++) begin
      bus.raddr = {5'(31 - r), 5'(r)};
      #1;
      check($sformatf("reset rdata0 r%0d", r), bus.rdata[31:0], 32'h0);
      check($sformatf("reset rready r%0d", r), {30'h0, bus.rready}, 32'h3);
    end
    check("reset busy_cnt", {26'h0, bus.busy_cnt}, 32'h0);
    check("reset alloc_ok", {31'h0, bus.alloc_ok}, 32'h1);

    // Directed table
    for (int k = 0; k < 18; k++) begin
      drive(vt[k].we, vt[k].wa0, vt[k].wd0, vt[k].wa1, vt[k].wd1,
            vt[k].ra0, vt[k].ra1, vt[k].av, vt[k].aa, vt[k].fl);
      #2;
      check($sformatf("vec%0d rdata0", k), bus.rdata[31:0], vt[k].e_rd0);
      check($sformatf("vec%0d rready0", k), {31'h0, bus.rready[0]}, {31'h0, vt[k].e_rr0});
      check($sformatf("vec%0d rdata1", k), bus.rdata[63:32], vt[k].e_rd1);
      check($sformatf("vec%0d rready1", k), {31'h0, bus.rready[1]}, {31'h0, vt[k].e_rr1});
      check($sformatf("vec%0d alloc_ok", k), {31'h0, bus.alloc_ok}, {31'h0, vt[k].e_ok});
      check($sformatf("vec%0d busy_cnt", k), {26'h0, bus.busy_cnt}, {26'h0, vt[k].e_cnt});
      tick();
    end

    // Reset arriving mid-operation discards that cycle's alloc and write
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 5'd5, 1'b1, 5'd12, 1'b0);
    tick();
    #1;
    check("midrst pre busy_cnt", {26'h0, bus.busy_cnt}, 32'h1);
    check("midrst pre rready12", {31'h0, bus.rready[0]}, 32'h0);
    rst = 1'b1;
    drive(2'b01, 5'd14, 32'h99, 5'd0, 32'h0, 5'd12, 5'd5, 1'b1, 5'd13, 1'b0);
    tick();
    rst = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 5'd14, 1'b0, 5'd13, 1'b0);
    #1;
    check("midrst busy_cnt", {26'h0, bus.busy_cnt}, 32'h0);
    check("midrst rready12", {31'h0, bus.rready[0]}, 32'h1);
    check("midrst rdata14", bus.rdata[63:32], 32'h0);
    check("midrst alloc_ok13", {31'h0, bus.alloc_ok}, 32'h1);
    bus.raddr = {5'd10, 5'd5};
    #1;
    check("midrst rdata5", bus.rdata[31:0], 32'h0);
    check("midrst rdata10", bus.rdata[63:32], 32'h0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst             = ($urandom_range(0, 79) == 0);
      bus.we          = 2'($urandom_range(0, 3));
      bus.waddr       = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      bus.wdata       = {$urandom, $urandom};
      bus.raddr       = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      bus.alloc_valid = 1'($urandom_range(0, 1));
      bus.alloc_addr  = 5'($urandom_range(0, 15));
      bus.flush       = ($urandom_range(0, 19) == 0);
      #2;
      check_model($sformatf("rnd%0d", c));
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
